// File: rtl/reorder_buffer_if.sv
// Issue, writeback, lookup and commit signals between the reorder buffer and the rest of the core.
// slave = reorder buffer side, master = decoder / execution units / RegFile side.
interface reorder_buffer_if #(
  parameter int ROB_WIDTH_BIT = 3
);
  logic                     issue_valid;
  logic [1:0]               issue_type;
  logic [4:0]               issue_rd;
  logic [31:0]              issue_pred_pc;
  logic                     rob_full;
  logic [ROB_WIDTH_BIT-1:0] issue_rob_id;
  logic [4:0]               new_reg_id;
  logic [ROB_WIDTH_BIT-1:0] new_ROB_id;

  logic                     alu_cdb_valid;
  logic [ROB_WIDTH_BIT-1:0] alu_cdb_rob_id;
  logic [31:0]              alu_cdb_val;
  logic [31:0]              alu_cdb_pc;
  logic                     lsb_cdb_valid;
  logic [ROB_WIDTH_BIT-1:0] lsb_cdb_rob_id;
  logic [31:0]              lsb_cdb_val;

  logic [ROB_WIDTH_BIT-1:0] rs1_id;
  logic [ROB_WIDTH_BIT-1:0] rs2_id;
  logic                     rs1_ready;
  logic                     rs2_ready;
  logic [31:0]              rs1_val;
  logic [31:0]              rs2_val;

  logic [4:0]               write_reg_id;
  logic [ROB_WIDTH_BIT-1:0] write_ROB_id;
  logic [31:0]              write_val;
  logic                     store_commit;
  logic                     clear_flag;
  logic [31:0]              redirect_pc;

  modport slave (
    input  issue_valid, issue_type, issue_rd, issue_pred_pc,
    input  alu_cdb_valid, alu_cdb_rob_id, alu_cdb_val, alu_cdb_pc,
    input  lsb_cdb_valid, lsb_cdb_rob_id, lsb_cdb_val,
    input  rs1_id, rs2_id,
    output rob_full, issue_rob_id, new_reg_id, new_ROB_id,
    output rs1_ready, rs2_ready, rs1_val, rs2_val,
    output write_reg_id, write_ROB_id, write_val, store_commit,
    output clear_flag, redirect_pc
  );

  modport master (
    output issue_valid, issue_type, issue_rd, issue_pred_pc,
    output alu_cdb_valid, alu_cdb_rob_id, alu_cdb_val, alu_cdb_pc,
    output lsb_cdb_valid, lsb_cdb_rob_id, lsb_cdb_val,
    output rs1_id, rs2_id,
    input  rob_full, issue_rob_id, new_reg_id, new_ROB_id,
    input  rs1_ready, rs2_ready, rs1_val, rs2_val,
    input  write_reg_id, write_ROB_id, write_val, store_commit,
    input  clear_flag, redirect_pc
  );
endinterface

// File: rtl/reorder_buffer.sv
// Circular in-order reorder buffer: tag allocation, CDB capture, operand bypass, one commit per cycle.
// Issue/commit outputs are combinational; mispredict flush is a registered one-cycle clear_flag; rdy_in=0 freezes state.
module reorder_buffer #(
  parameter int ROB_WIDTH_BIT = 3
) (
  input  logic            clk_in,
  input  logic            rst_in,
  input  logic            rdy_in,
  reorder_buffer_if.slave bus
);
  localparam int W     = ROB_WIDTH_BIT;
  localparam int DEPTH = 1 << W;
  localparam logic [W:0] CNT_FULL = {1'b1, {W{1'b0}}};
  localparam logic [1:0] T_STORE  = 2'd1;
  localparam logic [1:0] T_BRANCH = 2'd2;

  typedef struct packed {
    logic        busy;
    logic        ready;
    logic [1:0]  typ;
    logic [4:0]  rd;
    logic [31:0] val;
    logic [31:0] pred_pc;
    logic [31:0] real_pc;
  } entry_t;

  entry_t       r_ent [DEPTH];
  logic [W-1:0] r_head;
  logic [W-1:0] r_tail;
  logic [W:0]   r_count;
  logic         r_clear;
  logic [31:0]  r_redirect;

  entry_t w_hd;
  logic   w_full;
  logic   w_accept;
  logic   w_commit;
  logic   w_mispredict;
  logic   w_alu_wb;
  logic   w_lsb_wb;

  assign w_hd         = r_ent[r_head];
  assign w_full       = (r_count == CNT_FULL);
  assign w_accept     = bus.issue_valid && !w_full && rdy_in && !r_clear;
  assign w_commit     = w_hd.busy && w_hd.ready && rdy_in && !r_clear;
  assign w_mispredict = w_commit && (w_hd.typ == T_BRANCH) && (w_hd.real_pc != w_hd.pred_pc);
  assign w_alu_wb     = bus.alu_cdb_valid && r_ent[bus.alu_cdb_rob_id].busy && rdy_in && !r_clear;
  assign w_lsb_wb     = bus.lsb_cdb_valid && r_ent[bus.lsb_cdb_rob_id].busy && rdy_in && !r_clear;

  assign bus.rob_full     = w_full;
  assign bus.issue_rob_id = r_tail;
  assign bus.new_reg_id   = w_accept ? bus.issue_rd : 5'd0;
  assign bus.new_ROB_id   = w_accept ? r_tail : '0;
  assign bus.write_reg_id = (w_commit && w_hd.typ != T_STORE) ? w_hd.rd : 5'd0;
  assign bus.write_ROB_id = r_head;
  assign bus.write_val    = w_commit ? w_hd.val : 32'd0;
  assign bus.store_commit = w_commit && (w_hd.typ == T_STORE);
  assign bus.clear_flag   = r_clear;
  assign bus.redirect_pc  = r_redirect;

  // Stored result wins; otherwise forward a result landing on a CDB this very cycle.
  always_comb begin
    bus.rs1_ready = 1'b0;
    bus.rs1_val   = 32'd0;
    if (r_ent[bus.rs1_id].ready) begin
      bus.rs1_ready = 1'b1;
      bus.rs1_val   = r_ent[bus.rs1_id].val;
    end else if (bus.alu_cdb_valid && bus.alu_cdb_rob_id == bus.rs1_id) begin
      bus.rs1_ready = 1'b1;
      bus.rs1_val   = bus.alu_cdb_val;
    end else if (bus.lsb_cdb_valid && bus.lsb_cdb_rob_id == bus.rs1_id) begin
      bus.rs1_ready = 1'b1;
      bus.rs1_val   = bus.lsb_cdb_val;
    end
  end

  always_comb begin
    bus.rs2_ready = 1'b0;
    bus.rs2_val   = 32'd0;
    if (r_ent[bus.rs2_id].ready) begin
      bus.rs2_ready = 1'b1;
      bus.rs2_val   = r_ent[bus.rs2_id].val;
    end else if (bus.alu_cdb_valid && bus.alu_cdb_rob_id == bus.rs2_id) begin
      bus.rs2_ready = 1'b1;
      bus.rs2_val   = bus.alu_cdb_val;
    end else if (bus.lsb_cdb_valid && bus.lsb_cdb_rob_id == bus.rs2_id) begin
      bus.rs2_ready = 1'b1;
      bus.rs2_val   = bus.lsb_cdb_val;
    end
  end

  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      for (int i = 0; i < DEPTH; i++) r_ent[i] <= '0;
      r_head     <= '0;
      r_tail     <= '0;
      r_count    <= '0;
      r_clear    <= 1'b0;
      r_redirect <= 32'd0;
    end else if (rdy_in) begin
      r_clear <= 1'b0;
      if (w_mispredict) begin
        // The branch's own rd write goes out combinationally this cycle; everything younger is squashed.
        for (int i = 0; i < DEPTH; i++) begin
          r_ent[i].busy  <= 1'b0;
          r_ent[i].ready <= 1'b0;
        end
        r_head     <= '0;
        r_tail     <= '0;
        r_count    <= '0;
        r_clear    <= 1'b1;
        r_redirect <= w_hd.real_pc;
      end else begin
        if (w_accept) begin
          r_ent[r_tail] <= '{busy: 1'b1, ready: 1'b0, typ: bus.issue_type, rd: bus.issue_rd,
                             val: 32'd0, pred_pc: bus.issue_pred_pc, real_pc: 32'd0};
          r_tail <= r_tail + 1'b1;
        end
        if (w_alu_wb) begin
          r_ent[bus.alu_cdb_rob_id].ready   <= 1'b1;
          r_ent[bus.alu_cdb_rob_id].val     <= bus.alu_cdb_val;
          r_ent[bus.alu_cdb_rob_id].real_pc <= bus.alu_cdb_pc;
        end
        if (w_lsb_wb) begin
          r_ent[bus.lsb_cdb_rob_id].ready <= 1'b1;
          r_ent[bus.lsb_cdb_rob_id].val   <= bus.lsb_cdb_val;
        end
        if (w_commit) begin
          r_ent[r_head].busy  <= 1'b0;
          r_ent[r_head].ready <= 1'b0;
          r_head <= r_head + 1'b1;
        end
        case ({w_accept, w_commit})
          2'b10:   r_count <= r_count + 1'b1;
          2'b01:   r_count <= r_count - 1'b1;
          default: r_count <= r_count;
        endcase
      end
    end
  end
endmodule

// File: tb/tb_reorder_buffer.sv
// Scenario bench for reorder_buffer: expected commits are queued at issue and popped when the ROB retires them.
module tb_reorder_buffer;
  localparam int W = 3;

  logic clk_in = 1'b0;
  logic rst_in = 1'b0;
  logic rdy_in = 1'b1;

  reorder_buffer_if #(.ROB_WIDTH_BIT(W)) bus ();

  reorder_buffer #(.ROB_WIDTH_BIT(W)) dut (
    .clk_in (clk_in),
    .rst_in (rst_in),
    .rdy_in (rdy_in),
    .bus    (bus)
  );

  always #5 clk_in = ~clk_in;

  typedef struct {
    logic [4:0]   rd;
    logic [W-1:0] tag;
    logic [31:0]  val;
    logic         st;
  } exp_t;

  exp_t         sb[$];
  int           checks = 0;
  int           errors = 0;
  logic [W-1:0] m_tail = '0;

  task automatic idle();
    bus.issue_valid    = 1'b0;
    bus.issue_type     = 2'd0;
    bus.issue_rd       = 5'd0;
    bus.issue_pred_pc  = 32'd0;
    bus.alu_cdb_valid  = 1'b0;
    bus.alu_cdb_rob_id = '0;
    bus.alu_cdb_val    = 32'd0;
    bus.alu_cdb_pc     = 32'd0;
    bus.lsb_cdb_valid  = 1'b0;
    bus.lsb_cdb_rob_id = '0;
    bus.lsb_cdb_val    = 32'd0;
    bus.rs1_id         = '0;
    bus.rs2_id         = '0;
  endtask

  task automatic step();
    @(posedge clk_in);
    #1;
  endtask

  task automatic settle();
    @(negedge clk_in);
  endtask

  task automatic issue(input logic [1:0] t, input logic [4:0] rd, input logic [31:0] pred, input logic [31:0] val);
    exp_t e;
    bus.issue_valid   = 1'b1;
    bus.issue_type    = t;
    bus.issue_rd      = rd;
    bus.issue_pred_pc = pred;
    e.rd  = (t == 2'd1) ? 5'd0 : rd;
    e.tag = m_tail;
    e.val = val;
    e.st  = (t == 2'd1);
    sb.push_back(e);
    m_tail = m_tail + 1'b1;
  endtask

  task automatic alu_wb(input int idx, input logic [31:0] pc);
    bus.alu_cdb_valid  = 1'b1;
    bus.alu_cdb_rob_id = sb[idx].tag;
    bus.alu_cdb_val    = sb[idx].val;
    bus.alu_cdb_pc     = pc;
  endtask

  task automatic lsb_wb(input int idx);
    bus.lsb_cdb_valid  = 1'b1;
    bus.lsb_cdb_rob_id = sb[idx].tag;
    bus.lsb_cdb_val    = sb[idx].val;
  endtask

  task automatic test_reset();
    rdy_in = 1'b1;
    idle();
    rst_in = 1'b0;
    #12;
    checks++; if (bus.rob_full !== 1'b0) begin errors++; $display("FAIL reset_rob_full: got %0b want 0", bus.rob_full); end
    checks++; if (bus.issue_rob_id !== 3'd0) begin errors++; $display("FAIL reset_issue_rob_id: got %0d want 0", bus.issue_rob_id); end
    checks++; if (bus.write_reg_id !== 5'd0) begin errors++; $display("FAIL reset_write_reg_id: got %0d want 0", bus.write_reg_id); end
    checks++; if (bus.write_val !== 32'd0) begin errors++; $display("FAIL reset_write_val: got %0h want 0", bus.write_val); end
    checks++; if (bus.store_commit !== 1'b0) begin errors++; $display("FAIL reset_store_commit: got %0b want 0", bus.store_commit); end
    checks++; if (bus.clear_flag !== 1'b0) begin errors++; $display("FAIL reset_clear_flag: got %0b want 0", bus.clear_flag); end
    checks++; if (bus.redirect_pc !== 32'd0) begin errors++; $display("FAIL reset_redirect_pc: got %0h want 0", bus.redirect_pc); end
    checks++; if (bus.rs1_ready !== 1'b0 || bus.rs1_val !== 32'd0) begin errors++; $display("FAIL reset_rs1: got %0b/%0h want 0/0", bus.rs1_ready, bus.rs1_val); end
    rst_in = 1'b1;
  endtask

  task automatic test_basic();
    exp_t e;
    step(); idle();
    issue(2'd0, 5'd5, 32'd0, 32'h2A);
    settle();
    checks++; if (bus.new_reg_id !== 5'd5) begin errors++; $display("FAIL basic_new_reg_id: got %0d want 5", bus.new_reg_id); end
    checks++; if (bus.new_ROB_id !== 3'd0) begin errors++; $display("FAIL basic_new_ROB_id: got %0d want 0", bus.new_ROB_id); end
    step(); idle();
    alu_wb(0, 32'd0);
    settle();
    checks++; if (bus.write_reg_id !== 5'd0) begin errors++; $display("FAIL basic_early_commit: got %0d want 0", bus.write_reg_id); end
    step(); idle();
    settle();
    e = sb.pop_front();
    checks++; if (bus.write_reg_id !== e.rd || bus.write_ROB_id !== e.tag || bus.write_val !== e.val) begin
      errors++; $display("FAIL basic_commit: got rd=%0d tag=%0d val=%0h want rd=%0d tag=%0d val=%0h",
                         bus.write_reg_id, bus.write_ROB_id, bus.write_val, e.rd, e.tag, e.val); end
    step();
    settle();
    checks++; if (bus.write_reg_id !== 5'd0) begin errors++; $display("FAIL basic_no_second_commit: got %0d want 0", bus.write_reg_id); end
  endtask

  task automatic test_fill_and_wrap();
    exp_t e;
    for (int i = 0; i < 8; i++) begin
      step(); idle();
      issue(2'd0, 5'(10 + i), 32'd0, (m_tail == 3'd3) ? 32'h77 : $urandom);
      settle();
      checks++; if (bus.new_ROB_id !== sb[$].tag || bus.new_reg_id !== 5'(10 + i)) begin
        errors++; $display("FAIL fill_issue_%0d: got tag=%0d rd=%0d want tag=%0d rd=%0d",
                           i, bus.new_ROB_id, bus.new_reg_id, sb[$].tag, 10 + i); end
    end
    step(); idle();
    bus.issue_valid = 1'b1; bus.issue_rd = 5'd20;
    settle();
    checks++; if (bus.rob_full !== 1'b1 || bus.new_reg_id !== 5'd0 || bus.issue_rob_id !== m_tail) begin
      errors++; $display("FAIL fill_full_block: got full=%0b rd=%0d tail=%0d want 1/0/%0d",
                         bus.rob_full, bus.new_reg_id, bus.issue_rob_id, m_tail); end
    step();
    alu_wb(0, 32'd0);
    settle();
    step();
    bus.alu_cdb_valid = 1'b0;
    settle();
    e = sb.pop_front();
    checks++; if (bus.write_reg_id !== e.rd || bus.write_val !== e.val || bus.new_reg_id !== 5'd0 || bus.rob_full !== 1'b1) begin
      errors++; $display("FAIL fill_commit_while_full: got rd=%0d val=%0h new=%0d full=%0b want rd=%0d val=%0h new=0 full=1",
                         bus.write_reg_id, bus.write_val, bus.new_reg_id, bus.rob_full, e.rd, e.val); end
    step(); idle();
    issue(2'd0, 5'd21, 32'd0, $urandom);
    settle();
    checks++; if (bus.rob_full !== 1'b0 || bus.new_reg_id !== 5'd21 || bus.new_ROB_id !== sb[$].tag) begin
      errors++; $display("FAIL fill_reissue: got full=%0b rd=%0d tag=%0d want 0/21/%0d",
                         bus.rob_full, bus.new_reg_id, bus.new_ROB_id, sb[$].tag); end
    // Out-of-order writebacks; head (sb[0]) completes last.
    step(); idle();
    alu_wb(1, 32'd0); lsb_wb(3);
    bus.rs1_id = sb[1].tag; bus.rs2_id = sb[3].tag;
    settle();
    checks++; if (bus.rs1_ready !== 1'b1 || bus.rs1_val !== 32'h77 || bus.rs1_id !== 3'd3) begin
      errors++; $display("FAIL bypass_alu_rs1: got rdy=%0b val=%0h id=%0d want 1/77/3", bus.rs1_ready, bus.rs1_val, bus.rs1_id); end
    checks++; if (bus.rs2_ready !== 1'b1 || bus.rs2_val !== sb[3].val) begin
      errors++; $display("FAIL bypass_lsb_rs2: got rdy=%0b val=%0h want 1/%0h", bus.rs2_ready, bus.rs2_val, sb[3].val); end
    checks++; if (bus.write_reg_id !== 5'd0) begin errors++; $display("FAIL drain_head_not_ready: got %0d want 0", bus.write_reg_id); end
    step(); idle();
    alu_wb(2, 32'd0); lsb_wb(4);
    bus.rs1_id = sb[1].tag; bus.rs2_id = sb[5].tag;
    settle();
    checks++; if (bus.rs1_ready !== 1'b1 || bus.rs1_val !== 32'h77) begin
      errors++; $display("FAIL lookup_stored: got rdy=%0b val=%0h want 1/77", bus.rs1_ready, bus.rs1_val); end
    checks++; if (bus.rs2_ready !== 1'b0 || bus.rs2_val !== 32'd0) begin
      errors++; $display("FAIL lookup_not_ready: got rdy=%0b val=%0h want 0/0", bus.rs2_ready, bus.rs2_val); end
    step(); idle();
    alu_wb(5, 32'd0); lsb_wb(6);
    step(); idle();
    alu_wb(7, 32'd0); lsb_wb(0);
    for (int i = 0; i < 8; i++) begin
      step(); idle();
      settle();
      e = sb.pop_front();
      checks++; if (bus.write_reg_id !== e.rd || bus.write_ROB_id !== e.tag || bus.write_val !== e.val) begin
        errors++; $display("FAIL drain_commit_%0d: got rd=%0d tag=%0d val=%0h want rd=%0d tag=%0d val=%0h",
                           i, bus.write_reg_id, bus.write_ROB_id, bus.write_val, e.rd, e.tag, e.val); end
    end
    step();
    settle();
    checks++; if (bus.write_reg_id !== 5'd0 || bus.rob_full !== 1'b0 || bus.issue_rob_id !== m_tail) begin
      errors++; $display("FAIL drain_empty: got rd=%0d full=%0b tail=%0d want 0/0/%0d",
                         bus.write_reg_id, bus.rob_full, bus.issue_rob_id, m_tail); end
  endtask

  task automatic test_store_rdy();
    exp_t e;
    step(); idle();
    issue(2'd1, 5'd9, 32'd0, $urandom);
    step(); idle();
    lsb_wb(0);
    step(); idle();
    rdy_in = 1'b0;
    bus.issue_valid = 1'b1; bus.issue_rd = 5'd22;
    settle();
    checks++; if (bus.store_commit !== 1'b0 || bus.write_reg_id !== 5'd0 || bus.new_reg_id !== 5'd0) begin
      errors++; $display("FAIL store_frozen: got sc=%0b rd=%0d new=%0d want 0/0/0",
                         bus.store_commit, bus.write_reg_id, bus.new_reg_id); end
    step(); idle();
    rdy_in = 1'b1;
    settle();
    e = sb.pop_front();
    checks++; if (bus.store_commit !== 1'b1 || bus.write_reg_id !== 5'd0 || bus.write_ROB_id !== e.tag || bus.write_val !== e.val) begin
      errors++; $display("FAIL store_commit: got sc=%0b rd=%0d tag=%0d val=%0h want 1/0/%0d/%0h",
                         bus.store_commit, bus.write_reg_id, bus.write_ROB_id, bus.write_val, e.tag, e.val); end
    step();
    settle();
    checks++; if (bus.store_commit !== 1'b0) begin errors++; $display("FAIL store_pulse_width: got %0b want 0", bus.store_commit); end
  endtask

  task automatic test_mispredict();
    exp_t e;
    step(); idle();
    issue(2'd2, 5'd3, 32'h300, $urandom);
    step(); idle();
    alu_wb(0, 32'h300);
    step(); idle();
    settle();
    e = sb.pop_front();
    checks++; if (bus.write_reg_id !== e.rd || bus.write_val !== e.val) begin
      errors++; $display("FAIL branch_ok_commit: got rd=%0d val=%0h want rd=%0d val=%0h", bus.write_reg_id, bus.write_val, e.rd, e.val); end
    step();
    settle();
    checks++; if (bus.clear_flag !== 1'b0) begin errors++; $display("FAIL branch_ok_no_clear: got %0b want 0", bus.clear_flag); end
    step(); idle();
    issue(2'd2, 5'd1, 32'h100, $urandom);
    step(); idle();
    issue(2'd0, 5'd2, 32'd0, $urandom);
    alu_wb(0, 32'h200);
    step(); idle();
    lsb_wb(1);
    bus.issue_valid = 1'b1; bus.issue_rd = 5'd24;
    settle();
    e = sb.pop_front();
    checks++; if (bus.write_reg_id !== 5'd1 || bus.write_val !== e.val || bus.clear_flag !== 1'b0) begin
      errors++; $display("FAIL mispredict_commit: got rd=%0d val=%0h clr=%0b want 1/%0h/0",
                         bus.write_reg_id, bus.write_val, bus.clear_flag, e.val); end
    step(); idle();
    bus.issue_valid = 1'b1; bus.issue_rd = 5'd23;
    settle();
    sb.delete();
    m_tail = '0;
    checks++; if (bus.clear_flag !== 1'b1 || bus.redirect_pc !== 32'h200) begin
      errors++; $display("FAIL mispredict_clear: got clr=%0b pc=%0h want 1/200", bus.clear_flag, bus.redirect_pc); end
    checks++; if (bus.new_reg_id !== 5'd0 || bus.issue_rob_id !== 3'd0 || bus.write_reg_id !== 5'd0) begin
      errors++; $display("FAIL mispredict_flushed: got new=%0d tail=%0d rd=%0d want 0/0/0",
                         bus.new_reg_id, bus.issue_rob_id, bus.write_reg_id); end
    step(); idle();
    settle();
    checks++; if (bus.clear_flag !== 1'b0 || bus.issue_rob_id !== 3'd0) begin
      errors++; $display("FAIL mispredict_after: got clr=%0b tail=%0d want 0/0", bus.clear_flag, bus.issue_rob_id); end
  endtask

  task automatic test_async_reset();
    step(); idle();
    issue(2'd0, 5'd4, 32'd0, $urandom);
    step(); idle();
    issue(2'd0, 5'd6, 32'd0, $urandom);
    alu_wb(0, 32'd0);
    step(); idle();
    bus.rs1_id = sb[0].tag;
    settle();
    checks++; if (bus.issue_rob_id !== m_tail || bus.write_reg_id !== 5'd4 || bus.rs1_ready !== 1'b1) begin
      errors++; $display("FAIL areset_pre: got tail=%0d rd=%0d rdy=%0b want %0d/4/1",
                         bus.issue_rob_id, bus.write_reg_id, bus.rs1_ready, m_tail); end
    #2 rst_in = 1'b0;
    #1;
    checks++; if (bus.issue_rob_id !== 3'd0 || bus.rob_full !== 1'b0 || bus.write_reg_id !== 5'd0 || bus.write_val !== 32'd0) begin
      errors++; $display("FAIL areset_now: got tail=%0d full=%0b rd=%0d val=%0h want 0/0/0/0",
                         bus.issue_rob_id, bus.rob_full, bus.write_reg_id, bus.write_val); end
    checks++; if (bus.rs1_ready !== 1'b0 || bus.rs1_val !== 32'd0 || bus.clear_flag !== 1'b0) begin
      errors++; $display("FAIL areset_lookup: got rdy=%0b val=%0h clr=%0b want 0/0/0", bus.rs1_ready, bus.rs1_val, bus.clear_flag); end
    #1 rst_in = 1'b1;
    sb.delete();
    m_tail = '0;
    step(); idle();
    issue(2'd0, 5'd7, 32'd0, $urandom);
    settle();
    checks++; if (bus.new_ROB_id !== 3'd0 || bus.new_reg_id !== 5'd7) begin
      errors++; $display("FAIL areset_reissue: got tag=%0d rd=%0d want 0/7", bus.new_ROB_id, bus.new_reg_id); end
  endtask

  initial begin
    idle();
    test_reset();
    test_basic();
    test_fill_and_wrap();
    test_store_rdy();
    test_mispredict();
    test_async_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
